// File: rtl/axi_stream_packet_scheduler_if.sv
// Stream bundle between NUM packet sources, the scheduler and the merged downstream port.
// master modport is the scheduler's view; slave is the source/sink environment view.
interface axi_stream_packet_scheduler_if #(
  parameter int NUM   = 4,
  parameter int DSIZE = 32
);
  logic [NUM*DSIZE-1:0] s_tdata;
  logic [NUM-1:0]       s_tvalid;
  logic [NUM-1:0]       s_tlast;
  logic [NUM-1:0]       s_tready;
  logic [DSIZE-1:0]     m_tdata;
  logic                 m_tvalid;
  logic                 m_tlast;
  logic                 m_tready;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/axi_stream_packet_scheduler.sv
// Packet-locked round-robin merge of NUM streams; 1-cycle grant latency, one idle cycle between packets.
// Sources see m_tready only while granted; admission waits for MAX_PKT words of downstream space. Optional stall timeout: AXI_PKT_SCHED_STALL_TIMEOUT_EN.
module axi_stream_packet_scheduler #(
  parameter int NUM     = 4,
  parameter int DSIZE   = 32,
  parameter int MAX_PKT = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic                      aclk,
  input  logic                      rst,
  axi_stream_packet_scheduler_if.master bus,
  input  logic [15:0]               down_empty_size,
  output logic [$clog2(NUM)-1:0]    grant_id,
  output logic                      busy,
  output logic                      oversize_err,
  output logic                      stall_err
);

  localparam int IW = $clog2(NUM);
  localparam logic [15:0] MAX_PKT_W = 16'(MAX_PKT);
  localparam logic [15:0] MAX_PKT_M1 = 16'(MAX_PKT - 1);

  if (NUM < 2 || NUM > 16 || MAX_PKT < 1 || MAX_PKT > 65535 || TIMEOUT < 1) begin : g_param_chk
    $error("axi_stream_packet_scheduler: parameter out of range");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IW-1:0]  r_rr_ptr;
  logic [IW-1:0]  r_grant_id;
  logic [15:0]    r_beat_cnt;
  logic           r_oversize_err;

  logic           w_credit_ok;
  logic           w_found;
  logic [IW-1:0]  w_winner;
  logic [IW-1:0]  w_cand;
  logic           w_src_vld;
  logic           w_src_last;
  logic           w_hs;

  // Explicit wrap so non-power-of-two NUM never lands on an unused index.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
    return (p == IW'(NUM - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_credit_ok = (down_empty_size >= MAX_PKT_W);
  assign w_src_vld   = bus.s_tvalid[r_grant_id];
  assign w_src_last  = bus.s_tlast[r_grant_id];
  assign w_hs        = (r_state == XFER) && w_src_vld && bus.m_tready;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = r_rr_ptr;
    for (int k = 0; k < NUM; k++) begin
      if (!w_found && bus.s_tvalid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
      w_cand = wrap_inc(w_cand);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.s_tready = '0;
    bus.m_tdata  = '0;
    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_credit_ok && w_found) w_state_nxt = XFER;
      end
      XFER: begin
        bus.m_tdata              = bus.s_tdata[r_grant_id*DSIZE +: DSIZE];
        bus.m_tvalid             = w_src_vld;
        bus.m_tlast              = w_src_last;
        bus.s_tready[r_grant_id] = bus.m_tready;
        if (w_hs && w_src_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_rr_ptr       <= '0;
      r_grant_id     <= '0;
      r_beat_cnt     <= '0;
      r_oversize_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_state_nxt == XFER) begin
        r_grant_id <= w_winner;
        r_beat_cnt <= '0;
      end
      if (w_hs) begin
        if (w_src_last) begin
          r_beat_cnt <= '0;
          r_rr_ptr   <= wrap_inc(r_grant_id);
        end else if (r_beat_cnt != 16'hFFFF) begin
          r_beat_cnt <= r_beat_cnt + 16'd1;
        end
        // The packet still flows; the flag only records that it ran long.
        if (!w_src_last && r_beat_cnt == MAX_PKT_M1) r_oversize_err <= 1'b1;
      end
    end
  end

`ifdef AXI_PKT_SCHED_STALL_TIMEOUT_EN
  logic [15:0] r_stall_cnt;
  logic        r_stall_err;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      if (r_state != XFER || w_state_nxt != XFER || w_hs) begin
        r_stall_cnt <= '0;
      end else if (!w_src_vld && r_stall_cnt != 16'hFFFF) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (r_state == XFER && r_stall_cnt >= 16'(TIMEOUT)) r_stall_err <= 1'b1;
    end
  end

  assign stall_err = r_stall_err;
`else
  assign stall_err = 1'b0;
`endif

  assign grant_id     = r_grant_id;
  assign busy         = (r_state == XFER);
  assign oversize_err = r_oversize_err;

endmodule

// File: tb/tb_axi_stream_packet_scheduler.sv
// Scoreboard bench: drivers push expected beats per source; a negedge monitor tracks a packet-level
// round-robin model and checks grants, readies, merged data and sticky flags every cycle.
module tb_axi_stream_packet_scheduler;
  localparam int NUM     = 4;
  localparam int DSIZE   = 32;
  localparam int MAX_PKT = 256;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [DSIZE-1:0] dat;
    logic             last;
  } beat_t;

  logic        aclk = 1'b0;
  logic        rst;
  logic [15:0] down_empty_size;
  logic [1:0]  grant_id;
  logic        busy, oversize_err, stall_err;

  axi_stream_packet_scheduler_if #(.NUM(NUM), .DSIZE(DSIZE)) bus ();

  axi_stream_packet_scheduler #(
    .NUM(NUM), .DSIZE(DSIZE), .MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT)
  ) dut (
    .aclk(aclk), .rst(rst), .bus(bus),
    .down_empty_size(down_empty_size), .grant_id(grant_id), .busy(busy),
    .oversize_err(oversize_err), .stall_err(stall_err)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_errors = 0;
  beat_t       drv_q [NUM][$];
  beat_t       exp_q [NUM][$];
  logic [NUM-1:0] hs_flag = '0;
  bit          force_off [NUM];
  int          gap_pct = 0;
  int          rdy_mode = 0;
  bit          tog = 1'b0;
  int          n_beats = 0;
  int          grant_log [$];

  // reference model state
  bit          m_busy = 0;
  int          m_owner = 0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_over = 0;
  bit          prev_busy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_pkt(input int src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.dat  = $urandom();
      b.last = (i == len - 1);
      drv_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM; i++)
      if (drv_q[i].size() != 0 || exp_q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic step();
    logic [NUM*DSIZE-1:0] td;
    logic [NUM-1:0]       tv, tl;
    beat_t                h;
    @(posedge aclk);
    #1;
    td = '0; tv = '0; tl = '0;
    for (int i = 0; i < NUM; i++) begin
      if (hs_flag[i] && drv_q[i].size() != 0) void'(drv_q[i].pop_front());
      if (drv_q[i].size() != 0) begin
        h = drv_q[i][0];
        td[i*DSIZE +: DSIZE] = h.dat;
        tl[i] = h.last;
        tv[i] = !force_off[i] && !(gap_pct > 0 && $urandom_range(0, 99) < gap_pct);
      end
    end
    hs_flag = '0;
    bus.s_tdata  = td;
    bus.s_tvalid = tv;
    bus.s_tlast  = tl;
    tog = ~tog;
    case (rdy_mode)
      1:       bus.m_tready = 1'($urandom_range(0, 1));
      2:       bus.m_tready = tog;
      default: bus.m_tready = 1'b1;
    endcase
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (!(all_empty() && !m_busy) && c < budget) begin
      step();
      c++;
    end
    chk({name, "_drain_timeout"}, (c >= budget), 0);
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_s_tready", bus.s_tready, 0);
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    chk("rst_m_tlast", bus.m_tlast, 0);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < NUM; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
      force_off[i] = 1'b0;
    end
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.s_tdata  = '0;
    repeat (2) @(posedge aclk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge aclk) begin
    beat_t e;
    bit    fnd;
    if (rst) begin
      chk("reset_busy", busy, 0);
      chk("reset_grant_id", grant_id, 0);
      chk("reset_oversize", oversize_err, 0);
      chk("reset_stall", stall_err, 0);
      chk("reset_s_tready", bus.s_tready, 0);
      chk("reset_m_out", {bus.m_tvalid, bus.m_tlast, bus.m_tdata}, 0);
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_over = 0;
      prev_busy = 0;
      hs_flag = '0;
    end else begin
      hs_flag = bus.s_tvalid & bus.s_tready;
      if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
      prev_busy = busy;
      chk("busy", busy, m_busy);
      if (m_busy) chk("grant_id", grant_id, m_owner);
      chk("s_tready", bus.s_tready, m_busy ? (NUM'(bus.m_tready) << m_owner) : 0);
      chk("m_tvalid", bus.m_tvalid, m_busy ? bus.s_tvalid[m_owner] : 1'b0);
      if (!m_busy) chk("idle_m_data", {bus.m_tlast, bus.m_tdata}, 0);
      chk("oversize_err", oversize_err, m_over);
`ifndef AXI_PKT_SCHED_STALL_TIMEOUT_EN
      chk("stall_err", stall_err, 0);
`endif
      if (m_busy && bus.s_tvalid[m_owner] && bus.m_tready) begin
        if (exp_q[m_owner].size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q[m_owner].pop_front();
          chk("m_tdata", bus.m_tdata, e.dat);
          chk("m_tlast", bus.m_tlast, e.last);
          n_beats++;
          m_cnt++;
          if (m_cnt == MAX_PKT && !e.last) m_over = 1;
          if (e.last) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % NUM;
            m_cnt  = 0;
          end
        end
      end else if (!m_busy && down_empty_size >= MAX_PKT && |bus.s_tvalid) begin
        fnd = 0;
        for (int k = 0; k < NUM; k++) begin
          int idx;
          idx = (m_ptr + k) % NUM;
          if (!fnd && bus.s_tvalid[idx]) begin
            fnd = 1;
            m_owner = idx;
          end
        end
        m_busy = 1;
        m_cnt  = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    down_empty_size = 16'd0;
    bus.s_tdata = '0; bus.s_tvalid = '0; bus.s_tlast = '0; bus.m_tready = 1'b1;
    for (int i = 0; i < NUM; i++) force_off[i] = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    rst = 1'b0;

    // two sources, simultaneous 3-beat packets
    down_empty_size = 16'd1000;
    grant_log.delete();
    push_pkt(0, 3);
    push_pkt(2, 3);
    drain("two_src", 200);
    chk("two_src_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("two_src_first", grant_log[0], 0);
      chk("two_src_second", grant_log[1], 2);
    end

    // fairness with all sources continuously valid
    do_reset();
    grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NUM; s++) push_pkt(s, 2);
    drain("fair", 300);
    chk("fair_grants", grant_log.size(), 8);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("fair_order", grant_log[i], i % NUM);

    // credit threshold blocks admission
    down_empty_size = 16'd255;
    push_pkt(1, 2);
    repeat (50) step();
    chk("credit_block_busy", busy, 0);
    down_empty_size = 16'd256;
    step();
    chk("credit_grant_busy", busy, 1);
    chk("credit_grant_id", grant_id, 1);
    drain("credit", 100);

    // oversize packet passes intact
    down_empty_size = 16'd1000;
    n_beats = 0;
    push_pkt(3, 258);
    drain("oversize", 600);
    chk("oversize_beats", n_beats, 258);
    chk("oversize_sticky", oversize_err, 1);
    do_reset();
    chk("oversize_cleared", oversize_err, 0);

    // m_tready toggling mid-packet
    rdy_mode = 2;
    n_beats = 0;
    push_pkt(1, 8);
    drain("toggle", 200);
    chk("toggle_beats", n_beats, 8);

    // randomized traffic, backpressure and credit
    rdy_mode = 1;
    gap_pct = 20;
    for (int c = 0; c < 400; c++) begin
      down_empty_size = ($urandom_range(0, 4) == 0) ? 16'd100 : 16'(256 + $urandom_range(0, 500));
      if ($urandom_range(0, 2) == 0) begin
        int s;
        s = $urandom_range(0, NUM - 1);
        if (drv_q[s].size() < 16) push_pkt(s, $urandom_range(1, 6));
      end
      step();
    end
    down_empty_size = 16'd1000;
    gap_pct = 0;
    drain("random", 3000);

    // granted source stalls mid-packet; grant is kept
    rdy_mode = 0;
    push_pkt(2, 6);
    push_pkt(0, 2);
    repeat (4) step();
    force_off[2] = 1'b1;
    repeat (20) step();
    chk("stall_busy", busy, 1);
    chk("stall_grant", grant_id, 2);
`ifdef AXI_PKT_SCHED_STALL_TIMEOUT_EN
    chk("stall_err_set", stall_err, 1);
`else
    chk("stall_err_off", stall_err, 0);
`endif
    force_off[2] = 1'b0;
    drain("stall", 200);

    // reset in the middle of a packet
    push_pkt(0, 10);
    repeat (4) step();
    chk("pre_rst_busy", busy, 1);
    do_reset();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi_stream_packet_scheduler.md
Name: axi_stream_packet_scheduler

Overview:
- Packet-granular round-robin arbiter that merges NUM AXI-stream sources, each normally the output of a packet FIFO, onto one master stream.
- A grant is locked for a whole packet, from the first beat to the tlast beat.
- A new packet is admitted only when the downstream packet FIFO reports enough free space (its empty_size) to hold a maximum-length packet.
- Sits between per-channel packet FIFOs and a shared downstream packet FIFO or link.

Parameters:
- NUM, 4, number of requesters (2..16).
- DSIZE, 32, tdata width.
- MAX_PKT, 256, maximum packet length in beats; also the admission credit threshold (1..65535).
- TIMEOUT, 1024, stall cycles before stall_err; used only when the optional feature is compiled in.

Ports:
- aclk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_tdata  in  NUM*DSIZE  source data; source i occupies [i*DSIZE +: DSIZE].
- s_tvalid  in  NUM  per-source valid.
- s_tlast  in  NUM  per-source last.
- s_tready  out  NUM  per-source ready.
- m_tdata  out  DSIZE  merged data.
- m_tvalid  out  1  merged valid.
- m_tlast  out  1  merged last.
- m_tready  in  1  downstream ready.
- down_empty_size  in  16  free words in the downstream FIFO, in the aclk domain.
- grant_id  out  $clog2(NUM)  index of the current owner; valid while busy=1.
- busy  out  1  a packet is in flight.
- oversize_err  out  1  sticky: a packet exceeded MAX_PKT beats.
- stall_err  out  1  sticky: grant-holder stall timeout (optional feature only; tied to 0 otherwise).

Behaviour:
- Reset (async assert, sync release) forces:
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0, beat_cnt=0;
  - oversize_err=0, stall_err=0;
  - all s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0.
- FSM states: IDLE, XFER.
- IDLE:
  - credit_ok = (down_empty_size >= MAX_PKT), compared at 16 bits unsigned.
  - If credit_ok and any s_tvalid: grant goes to the first set s_tvalid searching rr_ptr, rr_ptr+1, ... modulo NUM.
  - Next cycle: grant_id=winner, busy=1, state=XFER, beat_cnt=0.
  - Arbitration latency is exactly 1 cycle from valid to grant.
  - All outputs stay 0 while in IDLE.
  - If credit_ok=0, no grant is made regardless of requests.
- XFER, with g = grant_id:
  - m_tdata/m_tvalid/m_tlast are a combinational mux of source g; s_tready[g] = m_tready; all other s_tready = 0.
  - Each handshake (m_tvalid && m_tready) increments beat_cnt; beat_cnt saturates at 16'hFFFF.
  - Handshake with m_tlast=1: next cycle state=IDLE, busy=0, rr_ptr=(g+1) mod NUM, beat_cnt=0.
  - This gives one idle bubble between packets; back-to-back packets are therefore spaced by at least 1 cycle.
- Oversize:
  - If a handshake occurs with beat_cnt == MAX_PKT-1 and tlast=0, set oversize_err (sticky until reset).
  - The packet still passes unmodified; the grant remains until tlast.
- Fairness: with all sources continuously valid and credit always ok, grants rotate 0,1,..,NUM-1,0.
- Simultaneous events:
  - down_empty_size falling during XFER does not affect the packet in flight; credit is checked only in IDLE.
  - A request from a non-granted source during XFER waits; its s_tready stays 0.
- A source that drops s_tvalid mid-packet holds the grant indefinitely; there is no preemption.
- Reset mid-packet aborts the grant immediately; all outputs return to reset values.
- Widths: rr_ptr and grant_id are $clog2(NUM) bits; the modulo wrap at NUM-1 to 0 is explicit, including non-power-of-two NUM.

Optional Feature:
- Macro: AXI_PKT_SCHED_STALL_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit stall counter runs in XFER; it increments each cycle where m_tvalid=0 and clears on any handshake or on leaving XFER.
  - When the counter reaches TIMEOUT, stall_err is set (sticky).
  - The grant is not released; the flag is diagnostic only.
- Without the macro: no counter logic; stall_err is constant 0.

Test Plan:
- NUM=4; sources 0 and 2 each present one 3-beat packet at cycle 0; down_empty_size=1000; m_tready=1 -> grant_id=0 at cycle 1, beats 0..2 out, then IDLE, then grant_id=2. m_tdata order matches source data exactly.
- All 4 sources hold continuous 2-beat packets -> grant sequence 0,1,2,3,0,1; no s_tready asserted for a non-granted source.
- down_empty_size=255 with MAX_PKT=256 and source 1 valid -> no grant for 50 cycles. Raise it to 256 -> grant_id=1 exactly 1 cycle later.
- Source 3 sends a 258-beat packet with MAX_PKT=256 -> oversize_err rises after the 256th beat handshake; all 258 beats are delivered; m_tlast on beat 258.
- m_tready toggles 1,0,1,0 mid-packet -> each beat is transferred exactly once; no duplication or loss. Assert rst mid-packet -> s_tready=0, m_tvalid=0, busy=0 immediately.
- Macro defined, TIMEOUT=8: granted source drops s_tvalid for 8 cycles mid-packet -> stall_err=1, grant retained. Macro undefined -> stall_err stays 0.
